// File: rtl/cc_encoder_serial.sv
// cc_encoder_serial: serial (7,4) cyclic Hamming encoder, g(x) = 1 + x + x^3.
// Accepts m3..m0 under valid/ready, emits systematic codeword c6..c0 MSB first.
// Optional build macro CC_ENCODER_ERR_INJECT_EN adds a single-bit error
// injector (err_inj_en / err_inj_pos) that corrupts only the output stream.
module cc_encoder_serial #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             valid_in,
`ifdef CC_ENCODER_ERR_INJECT_EN
  input  logic             err_inj_en,
  input  logic [2:0]       err_inj_pos,
`endif
  output logic             ready_out,
  output logic             code_out,
  output logic             valid_out,
  output logic             sof_out,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    S_MSG0 = 3'd0,
    S_MSG1 = 3'd1,
    S_MSG2 = 3'd2,
    S_MSG3 = 3'd3,
    S_PAR0 = 3'd4,
    S_PAR1 = 3'd5,
    S_PAR2 = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_lfsr;
  logic [2:0]       w_lfsr_next;
  logic [2:0]       w_lfsr_base;
  logic             w_fb;
  logic             w_is_msg;
  logic             w_accept;
  logic             w_ready;
  logic             w_code_next;
  logic             w_valid_next;
  logic             w_sof_next;
  logic             w_flip;
  logic [2:0]       w_bit_idx;
  logic             r_code;
  logic             r_valid;
  logic             r_sof;
  logic [CNT_W-1:0] r_cnt;

  assign w_is_msg  = (r_state == S_MSG0) || (r_state == S_MSG1) ||
                     (r_state == S_MSG2) || (r_state == S_MSG3);
  assign w_ready   = w_is_msg;
  assign w_accept  = valid_in & w_ready;
  // Codeword bit index of the bit produced in the current state: MSGk -> c(6-k), PARk -> c(2-k).
  assign w_bit_idx = 3'd6 - r_state;

  // A new codeword always starts from a clean LFSR, whatever a prior abort left behind.
  assign w_lfsr_base = (r_state == S_MSG0) ? 3'b000 : r_lfsr;
  assign w_fb        = data_in ^ w_lfsr_base[2];

`ifdef CC_ENCODER_ERR_INJECT_EN
  logic       r_inj_en;
  logic [2:0] r_inj_pos;
  logic       w_inj_en;
  logic [2:0] w_inj_pos;

  // The first bit of a word uses the live controls; later bits use the values latched with it.
  assign w_inj_en  = (r_state == S_MSG0) ? err_inj_en  : r_inj_en;
  assign w_inj_pos = (r_state == S_MSG0) ? err_inj_pos : r_inj_pos;
  assign w_flip    = w_inj_en && (w_inj_pos != 3'd7) && (w_inj_pos == w_bit_idx);

  // Latch the injection controls on the first accepted bit of each codeword.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inj_en  <= 1'b0;
      r_inj_pos <= 3'd7;
    end else if ((r_state == S_MSG0) && w_accept) begin
      r_inj_en  <= err_inj_en;
      r_inj_pos <= err_inj_pos;
    end
  end
`else
  assign w_flip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_MSG0;
    else       r_state <= w_state_next;
  end

  // Next-state logic: message states wait for an accept, parity states run unconditionally.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_MSG0:  if (w_accept) w_state_next = S_MSG1;
      S_MSG1:  if (w_accept) w_state_next = S_MSG2;
      S_MSG2:  if (w_accept) w_state_next = S_MSG3;
      S_MSG3:  if (w_accept) w_state_next = S_PAR0;
      S_PAR0:  w_state_next = S_PAR1;
      S_PAR1:  w_state_next = S_PAR2;
      S_PAR2:  w_state_next = S_MSG0;
      default: w_state_next = S_MSG0;
    endcase
  end

  // Output/datapath decode: message bits pass through while dividing, parity shifts out r2.
  always_comb begin
    w_lfsr_next  = r_lfsr;
    w_code_next  = 1'b0;
    w_valid_next = 1'b0;
    w_sof_next   = 1'b0;
    if (w_is_msg) begin
      if (w_accept) begin
        w_lfsr_next  = {w_lfsr_base[1], w_lfsr_base[0] ^ w_fb, w_fb};
        w_code_next  = data_in ^ w_flip;
        w_valid_next = 1'b1;
        w_sof_next   = (r_state == S_MSG0);
      end
    end else begin
      w_lfsr_next  = {r_lfsr[1], r_lfsr[0], 1'b0};
      w_code_next  = r_lfsr[2] ^ w_flip;
      w_valid_next = 1'b1;
    end
  end

  // Registered outputs, LFSR and completed-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr  <= 3'b000;
      r_code  <= 1'b0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_lfsr  <= w_lfsr_next;
      r_code  <= w_code_next;
      r_valid <= w_valid_next;
      r_sof   <= w_sof_next;
      if (r_state == S_PAR2) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ready_out = w_ready;
  assign code_out  = r_code;
  assign valid_out = r_valid;
  assign sof_out   = r_sof;
  assign word_cnt  = r_cnt;

endmodule
